// File: rtl/instr_sequencer_if.sv
// Instruction stream and register-file port bundle for instr_sequencer.
// slave is the sequencer's view; master is the feeder and register file side.
interface instr_sequencer_if;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] X;
   logic [1:0] XADDR;
   logic [1:0] AADDR;
   logic [1:0] BADDR;
   logic       write;

   modport master (
      output instr, instr_valid, A, B,
      input  instr_ready, X, XADDR, AADDR, BADDR, write
   );

   modport slave (
      input  instr, instr_valid, A, B,
      output instr_ready, X, XADDR, AADDR, BADDR, write
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer and ALU in front of a 4x8-bit register file.
// Runs one instruction at a time through fetch, read, execute and writeback.
module instr_sequencer (
   input  logic               clk,
   input  logic               rst,
   instr_sequencer_if.slave   bus,
   output logic               zero,
   output logic               carry,
   output logic               retired
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IMM  = 3'd1;
   localparam logic [2:0] S_READ = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_MOV = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;
   localparam logic [3:0] OP_LDI = 4'h9;

   logic [2:0] state_reg, state_next;
   logic [3:0] op_reg;
   logic [1:0] d_reg;
   logic [1:0] aaddr_reg, baddr_reg;
   logic [7:0] x_reg;
   logic       zero_reg, carry_reg, retired_reg;

   logic       accept;
   logic [3:0] in_op;
   logic       in_is_alu, in_is_ldi;

   logic [8:0] sum, diff;
   logic [7:0] alu_res;
   logic       alu_carry;

   assign in_op     = bus.instr[7:4];
   assign in_is_alu = (in_op >= OP_ADD) && (in_op <= OP_SHR);
   assign in_is_ldi = (in_op == OP_LDI);
   assign accept    = bus.instr_valid && bus.instr_ready;

   // Bit 8 of the 9-bit difference is the borrow, i.e. Rd < Rs.
   assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
   assign diff = {1'b0, bus.A} - {1'b0, bus.B};

   always_comb begin
      alu_res   = bus.A;
      alu_carry = carry_reg;
      case (op_reg)
         OP_ADD: begin alu_res = sum[7:0];  alu_carry = sum[8];  end
         OP_SUB: begin alu_res = diff[7:0]; alu_carry = diff[8]; end
         OP_AND: begin alu_res = bus.A & bus.B; alu_carry = 1'b0; end
         OP_OR:  begin alu_res = bus.A | bus.B; alu_carry = 1'b0; end
         OP_XOR: begin alu_res = bus.A ^ bus.B; alu_carry = 1'b0; end
         OP_MOV: alu_res = bus.B;
         OP_SHL: begin alu_res = {bus.A[6:0], 1'b0}; alu_carry = bus.A[7]; end
         OP_SHR: begin alu_res = {1'b0, bus.A[7:1]}; alu_carry = bus.A[0]; end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               if (in_is_alu)      state_next = S_READ;
               else if (in_is_ldi) state_next = S_IMM;
               else                state_next = S_IDLE;
            end
         end
         S_IMM:   if (accept) state_next = S_WB;
         S_READ:  state_next = S_EXEC;
         S_EXEC:  state_next = S_WB;
         S_WB:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         op_reg      <= 4'h0;
         d_reg       <= 2'd0;
         aaddr_reg   <= 2'd0;
         baddr_reg   <= 2'd0;
         x_reg       <= 8'h00;
         zero_reg    <= 1'b0;
         carry_reg   <= 1'b0;
         retired_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         // NOP/undefined retire straight from IDLE; everything else retires in WB.
         retired_reg <= (state_next == S_WB) ||
                        ((state_reg == S_IDLE) && accept && !in_is_alu && !in_is_ldi);

         if ((state_reg == S_IDLE) && accept) begin
            op_reg <= in_op;
            d_reg  <= bus.instr[3:2];
            if (in_is_alu) begin
               aaddr_reg <= bus.instr[3:2];
               baddr_reg <= bus.instr[1:0];
            end
         end

         if ((state_reg == S_IMM) && accept) begin
            x_reg    <= bus.instr;
            zero_reg <= (bus.instr == 8'h00);
         end

         if (state_reg == S_EXEC) begin
            x_reg     <= alu_res;
            zero_reg  <= (alu_res == 8'h00);
            carry_reg <= alu_carry;
         end
      end
   end

   assign bus.instr_ready = (state_reg == S_IDLE) || (state_reg == S_IMM);
   assign bus.write       = (state_reg == S_WB);
   assign bus.X           = x_reg;
   assign bus.XADDR       = d_reg;
   assign bus.AADDR       = aaddr_reg;
   assign bus.BADDR       = baddr_reg;
   assign zero            = zero_reg;
   assign carry           = carry_reg;
   assign retired         = retired_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, reset corner cases and
// randomized instructions checked against an arithmetic reference model.
module tb_instr_sequencer;

   logic clk;
   logic rst;
   logic zero, carry, retired;

   instr_sequencer_if bus();

   instr_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .zero    (zero),
      .carry   (carry),
      .retired (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file with registered read ports.
   logic [7:0] rf [4] = '{default: 8'h00};
   always @(posedge clk) begin
      bus.A <= rf[bus.AADDR];
      bus.B <= rf[bus.BADDR];
      if (bus.write) rf[bus.XADDR] <= bus.X;
   end

   int wr_total = 0;
   always @(negedge clk) if (bus.write) wr_total <= wr_total + 1;

   int checks   = 0;
   int failures = 0;

   int rf_m [4] = '{default: 0};
   bit z_m = 1'b0;
   bit c_m = 1'b0;

   typedef struct {
      logic [7:0] ins;
      logic [7:0] imm;
      int         gap;
      logic       w;
      logic [7:0] x;
      logic [1:0] a;
      int         lat;
      logic       z;
      logic       c;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.instr       = b;
      bus.instr_valid = 1'b1;
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: byte %02h not taken in 20 cycles", b);
      end else begin
         @(posedge clk);
      end
      #1 bus.instr_valid = 1'b0;
   endtask

   // Reference model: plain integer arithmetic on the architectural state.
   task automatic model_exec(input logic [7:0] ins, input logic [7:0] imm,
                             output logic w, output logic [7:0] x, output logic [1:0] a,
                             output int lat, output logic z, output logic c);
      int op = int'(ins[7:4]);
      int d  = int'(ins[3:2]);
      int s  = int'(ins[1:0]);
      int ra = rf_m[d];
      int rb = rf_m[s];
      int r  = 0;
      bit cf = c_m;
      w   = 1'b1;
      lat = 3;
      case (op)
         1: begin r = ra + rb; cf = (r >= 256); r = r % 256; end
         2: begin r = ra - rb; cf = (r < 0); if (r < 0) r = r + 256; end
         3: begin r = ra & rb; cf = 1'b0; end
         4: begin r = ra | rb; cf = 1'b0; end
         5: begin r = ra ^ rb; cf = 1'b0; end
         6: r = rb;
         7: begin r = ra * 2; cf = (r >= 256); r = r % 256; end
         8: begin cf = (ra % 2 == 1); r = ra / 2; end
         9: begin r = int'(imm); lat = 1; end
         default: begin w = 1'b0; lat = 1; end
      endcase
      if (w) begin
         rf_m[d] = r;
         z_m = (r == 0);
         c_m = cf;
      end
      x = 8'(r);
      a = 2'(d);
      z = z_m;
      c = c_m;
   endtask

   task automatic exec_check(input string nm, input logic [7:0] ins, input logic [7:0] imm,
                             input int gap, input logic exp_w, input logic [7:0] exp_x,
                             input logic [1:0] exp_a, input int exp_lat,
                             input logic exp_z, input logic exp_c);
      int op = int'(ins[7:4]);
      int wcnt = 0, rcnt = 0, wlat = 0, rlat = 0;
      logic [7:0] wx = 8'h00;
      logic [1:0] wa = 2'd0, aa = 2'd0, ba = 2'd0;
      logic rdy1 = 1'b0;
      send_byte(ins);
      if (op == 9) begin
         repeat (gap) @(negedge clk);
         send_byte(imm);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            aa = bus.AADDR; ba = bus.BADDR; rdy1 = bus.instr_ready;
         end
         if (bus.write) begin
            wcnt++;
            if (wcnt == 1) begin wx = bus.X; wa = bus.XADDR; wlat = k; end
         end
         if (retired) begin rcnt++; rlat = k; end
      end
      chk({nm, " writes"}, wcnt, exp_w ? 1 : 0);
      if (exp_w) begin
         chk({nm, " X"}, int'(wx), int'(exp_x));
         chk({nm, " XADDR"}, int'(wa), int'(exp_a));
         chk({nm, " write_latency"}, wlat, exp_lat);
      end else begin
         chk({nm, " ready_after_nop"}, int'(rdy1), 1);
      end
      chk({nm, " retired_count"}, rcnt, 1);
      chk({nm, " retired_latency"}, rlat, exp_lat);
      if (op >= 1 && op <= 8) begin
         chk({nm, " AADDR"}, int'(aa), int'(ins[3:2]));
         chk({nm, " BADDR"}, int'(ba), int'(ins[1:0]));
      end
      chk({nm, " zero"}, int'(zero), int'(exp_z));
      chk({nm, " carry"}, int'(carry), int'(exp_c));
   endtask

   initial begin
      logic w, z, c;
      logic [7:0] x, ins, imm;
      logic [1:0] a;
      int lat, gap, wc;

      tbl[0]  = '{8'h94, 8'h7F, 2, 1'b1, 8'h7F, 2'd1, 1, 1'b0, 1'b0};
      tbl[1]  = '{8'h98, 8'h01, 0, 1'b1, 8'h01, 2'd2, 1, 1'b0, 1'b0};
      tbl[2]  = '{8'h16, 8'h00, 0, 1'b1, 8'h80, 2'd1, 3, 1'b0, 1'b0};
      tbl[3]  = '{8'h9C, 8'hFF, 1, 1'b1, 8'hFF, 2'd3, 1, 1'b0, 1'b0};
      tbl[4]  = '{8'h1E, 8'h00, 0, 1'b1, 8'h00, 2'd3, 3, 1'b1, 1'b1};
      tbl[5]  = '{8'h29, 8'h00, 0, 1'b1, 8'h81, 2'd2, 3, 1'b0, 1'b1};
      tbl[6]  = '{8'h94, 8'h81, 0, 1'b1, 8'h81, 2'd1, 1, 1'b0, 1'b1};
      tbl[7]  = '{8'h84, 8'h00, 0, 1'b1, 8'h40, 2'd1, 3, 1'b0, 1'b1};
      tbl[8]  = '{8'hF0, 8'h00, 0, 1'b0, 8'h00, 2'd0, 1, 1'b0, 1'b1};
      tbl[9]  = '{8'h67, 8'h00, 0, 1'b1, 8'h00, 2'd1, 3, 1'b1, 1'b1};
      tbl[10] = '{8'h90, 8'hC3, 0, 1'b1, 8'hC3, 2'd0, 1, 1'b0, 1'b1};
      tbl[11] = '{8'h70, 8'h00, 0, 1'b1, 8'h86, 2'd0, 3, 1'b0, 1'b1};
      tbl[12] = '{8'h31, 8'h00, 0, 1'b1, 8'h00, 2'd0, 3, 1'b1, 1'b0};

      // Reset held with a byte on offer: nothing captured, outputs at reset values.
      rst = 1'b0;
      bus.instr = 8'h16;
      bus.instr_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst write", int'(bus.write), 0);
      chk("rst X", int'(bus.X), 0);
      chk("rst XADDR", int'(bus.XADDR), 0);
      chk("rst AADDR", int'(bus.AADDR), 0);
      chk("rst BADDR", int'(bus.BADDR), 0);
      chk("rst zero", int'(zero), 0);
      chk("rst carry", int'(carry), 0);
      chk("rst retired", int'(retired), 0);
      chk("rst ready", int'(bus.instr_ready), 1);
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst ready", int'(bus.instr_ready), 1);
      chk("post_rst AADDR", int'(bus.AADDR), 0);
      chk("post_rst writes", wr_total, 0);

      for (int i = 0; i < 13; i++) begin
         model_exec(tbl[i].ins, tbl[i].imm, w, x, a, lat, z, c);
         exec_check($sformatf("vec%0d", i), tbl[i].ins, tbl[i].imm, tbl[i].gap,
                    tbl[i].w, tbl[i].x, tbl[i].a, tbl[i].lat, tbl[i].z, tbl[i].c);
      end

      for (int i = 0; i < 200; i++) begin
         int op = $urandom_range(0, 11);
         ins = 8'($urandom_range(0, 255));
         if (op <= 9) ins[7:4] = 4'(op);
         imm = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, 2);
         model_exec(ins, imm, w, x, a, lat, z, c);
         exec_check($sformatf("rnd%0d_%02h", i, ins), ins, imm, gap, w, x, a, lat, z, c);
      end

      // Reset during EXEC of ADD R1,R2: no writeback, flags cleared, R1 untouched.
      send_byte(8'h16);
      @(negedge clk);
      @(negedge clk);
      wc = wr_total;
      rst = 1'b0;
      #1;
      chk("abort write", int'(bus.write), 0);
      chk("abort zero", int'(zero), 0);
      chk("abort carry", int'(carry), 0);
      chk("abort retired", int'(retired), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort no_write", wr_total, wc);
      chk("abort R1_kept", int'(rf[1]), rf_m[1]);
      z_m = 1'b0;
      c_m = 1'b0;
      model_exec(8'h16, 8'h00, w, x, a, lat, z, c);
      exec_check("after_abort", 8'h16, 8'h00, 0, w, x, a, lat, z, c);

      for (int i = 0; i < 4; i++)
         chk($sformatf("final R%0d", i), int'(rf[i]), rf_m[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Multi-cycle instruction sequencer and ALU that sits directly upstream of the 4×8-bit register file.
- Accepts 8-bit instruction bytes over a valid/ready handshake and drives the file's write port (X, XADDR, write) and read addresses (AADDR, BADDR).
- Consumes the file's registered A/B read data and keeps zero/carry flags.
- Executes one instruction at a time: fetch → read → execute → writeback.

## Interface
- Parameters: none. Data is fixed at 8 bits and register addresses at 2 bits.
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- instr  in  8  instruction or immediate byte.
- instr_valid  in  1  instr holds a byte.
- instr_ready  out  1  sequencer can take a byte; high in IDLE and IMM only.
- A  in  8  register file read data, port A.
- B  in  8  register file read data, port B.
- X  out  8  writeback data to the register file.
- XADDR  out  2  writeback address.
- AADDR  out  2  read address, port A.
- BADDR  out  2  read address, port B.
- write  out  1  register file write strobe.
- zero  out  1  zero flag.
- carry  out  1  carry/borrow flag.
- retired  out  1  one-cycle pulse per completed instruction.

## Operation
- Instruction format: [7:4] opcode, [3:2] d (destination and first source), [1:0] s (second source).
- Opcodes:
  - 0 NOP
  - 1 ADD: Rd=Rd+Rs
  - 2 SUB: Rd=Rd−Rs
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV: Rd=Rs
  - 7 SHL: Rd=Rd<<1
  - 8 SHR: Rd=Rd>>1, logical
  - 9 LDI: Rd=next byte; s is ignored
  - A–F are treated as NOP.
- A byte is accepted on a posedge with instr_valid & instr_ready & rst high. The d/s/opcode fields are latched internally.
- States:
  - IDLE
    - accept ALU/MOV op → READ.
    - accept LDI → IMM.
    - accept NOP/undefined → IDLE, with retired pulse next cycle.
    - No byte → IDLE.
  - IMM: accept immediate byte → WB with X=immediate. Waits indefinitely while instr_valid is low.
  - READ: AADDR=d, BADDR=s, write=0. The register file samples A/B at the end of this cycle. Always → EXEC.
  - EXEC: A/B are valid. Result and flags are computed and registered. Always → WB.
  - WB: write=1, XADDR=d, X=result, retired=1 for this cycle. Always → IDLE.
- write is high only in WB. AADDR/BADDR hold their last values outside READ/EXEC.
- All outputs except instr_ready are registered or decoded from registered state. There is no combinational path from instr/instr_valid to any output.
- Arithmetic is 8-bit, modulo 256. The 9th bit feeds carry.
- Flags are updated at the end of EXEC, or at immediate capture for LDI:
  - ADD: carry = bit 8 of the sum.
  - SUB: carry = 1 iff Rd < Rs (borrow).
  - SHL/SHR: carry = shifted-out bit.
  - AND/OR/XOR: carry = 0.
  - MOV/LDI: carry unchanged.
  - zero = (result == 0) for all ops except NOP/undefined.
  - NOP/undefined: neither flag changes.
- No forwarding is needed. A writeback completes at the WB→IDLE edge, and the earliest following READ is at least one cycle later.

## Timing
- Latencies from accept edge:
  - ALU/MOV: write=1 in the 3rd cycle after accept (READ, EXEC, WB). The next accept is possible in the 4th.
  - LDI: write=1 in the cycle after immediate accept.
  - NOP: next accept possible the cycle after.
- Reset values (rst low, asynchronous): state IDLE, write=0, X=0x00, XADDR/AADDR/BADDR=0, zero=0, carry=0, retired=0.
  - instr_ready reads 1 during reset, but no byte is captured while rst is low.
- Reset mid-instruction (any state): the instruction is abandoned and write drops immediately. No partial writeback occurs. The aborted instruction produces no retired pulse.
- Bytes offered outside IDLE/IMM are not consumed; instr_ready is low.

## Test plan
- Reset: hold rst low 3 cycles with instr_valid=1 → all outputs at reset values and no capture. After release, instr_ready=1.
- LDI with valid gaps:
  - Send 0x94, idle 2 cycles, then 0x7F → one write of X=0x7F, XADDR=1; zero=0; retired pulses once.
  - Then LDI R2=0x01 (0x98, 0x01).
- ADD R1,R2 (0x16): READ shows AADDR=1, BADDR=2; write occurs 3 cycles after accept with X=0x80, XADDR=1; zero=0, carry=0.
- Overflow and SUB:
  - LDI R3=0xFF, then ADD R3,R2 (0x1E) → X=0x00, zero=1, carry=1.
  - SUB R2,R1 (0x29) with R1=0x80 → X=0x81, carry=1.
- Shift/logic/NOP: SHR R1 (0x84) with R1=0x81 → X=0x40, carry=1. Then opcode 0xF0 → no write, flags unchanged, retired pulse, instr_ready high next cycle.
- Reset during EXEC of ADD: write never asserts, flags are 0, and the destination register keeps its prior value. The next instruction after release executes normally.
